// File: rtl/inst_assembler.sv
// RV32I instruction assembler: packs pre-split fields into 32-bit words, queues them
// in a small FIFO and streams them into the IMEM write port at an auto-incrementing address.
module inst_assembler #(
  parameter int IMEM_AW = 14,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_fmt,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [2:0]         func3,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [6:0]         func7,
  input  logic [31:0]        imm,
  input  logic               base_load,
  input  logic [IMEM_AW-1:0] base_addr,
  input  logic               imem_busy,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_din,
  output logic [3:0]         imem_we,
  output logic [IMEM_AW:0]   count,
  output logic               empty,
  output logic               err
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = IMEM_AW + 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [31:0]        mem_q [DEPTH];
  logic [PW-1:0]      rdPtr_q, rdPtr_d;
  logic [PW-1:0]      wrPtr_q, wrPtr_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic [IMEM_AW-1:0] wptr_q, wptr_d;
  logic [IMEM_AW-1:0] lastAddr_q, lastAddr_d;
  logic [31:0]        lastDin_q, lastDin_d;
  logic [CW-1:0]      count_q, count_d;
  logic               err_q, err_d;

  logic [31:0] encWord;
  logic        fmtLegal;
  logic        full;
  logic        accept;
  logic        push;
  logic        pop;

  // Field packing; immediates are scattered exactly as the decoder expects to gather them.
  always_comb begin
    encWord  = 32'h0;
    fmtLegal = 1'b1;
    case (in_fmt)
      FMT_R: encWord = {func7, rs2, rs1, func3, rd, opcode};
      FMT_I: encWord = {imm[11:0], rs1, func3, rd, opcode};
      FMT_S: encWord = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      FMT_B: encWord = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      FMT_U: encWord = {imm[31:12], rd, opcode};
      FMT_J: encWord = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: fmtLegal = 1'b0;
    endcase
  end

  // A full FIFO refuses input even when popping: no same-cycle pass-through.
  assign full     = (occ_q == OW'(DEPTH));
  assign empty    = (occ_q == '0);
  assign in_ready = !rst && !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && fmtLegal;
  assign pop      = !rst && !empty && !imem_busy;

  assign imem_we   = pop ? 4'hF : 4'h0;
  assign imem_addr = pop ? wptr_q : lastAddr_q;
  assign imem_din  = pop ? mem_q[rdPtr_q] : lastDin_q;
  assign count     = count_q;
  assign err       = err_q;

  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    occ_d      = occ_q;
    wptr_d     = wptr_q;
    lastAddr_d = lastAddr_q;
    lastDin_d  = lastDin_q;
    count_d    = count_q;
    err_d      = err_q;

    if (push) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end

    if (pop) begin
      rdPtr_d    = rdPtr_q + PW'(1);
      lastAddr_d = wptr_q;
      lastDin_d  = mem_q[rdPtr_q];
      if (count_q != '1) begin
        count_d = count_q + CW'(1);
      end
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    // A reload wins over the post-write increment; the write itself used the old pointer.
    if (base_load) begin
      wptr_d = base_addr;
    end else if (pop) begin
      wptr_d = wptr_q + IMEM_AW'(1);
    end

    if (accept && !fmtLegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      occ_q      <= '0;
      wptr_q     <= '0;
      lastAddr_q <= '0;
      lastDin_q  <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      lastAddr_q <= lastAddr_d;
      lastDin_q  <= lastDin_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= encWord;
    end
  end

endmodule

// File: doc/inst_assembler.md
# inst_assembler

Instruction assembler and IMEM writer: the encoding counterpart of the core's instruction field decoder. It takes pre-split RISC-V fields (opcode, rd, func3, rs1, rs2, func7, immediate) and a format tag over a valid/ready handshake, and packs them into a 32-bit RV32I instruction word. It buffers the words in a small FIFO and streams them into the instruction memory write port at an auto-incrementing word address. It is used by the BIOS-side loader and by self-test benches to generate programs in hardware.

## Interface
- IMEM_AW, 14, IMEM word-address width
- DEPTH, 4, FIFO depth in words; power of two, ≥2

- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  field bundle valid
- in_ready  output  1  assembler can accept; equals !rst && !fifo_full
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6–7 illegal
- opcode  input  7  instruction[6:0]
- rd  input  5  destination register
- func3  input  3  funct3
- rs1  input  5  source register 1
- rs2  input  5  source register 2
- func7  input  7  funct7 (R only)
- imm  input  32  immediate, RISC-V byte-offset semantics
- base_load  input  1  load write pointer from base_addr
- base_addr  input  IMEM_AW  new write pointer value
- imem_busy  input  1  IMEM port unavailable this cycle
- imem_addr  output  IMEM_AW  IMEM word address
- imem_din  output  32  encoded instruction
- imem_we  output  4  byte write enables; 4'hF or 4'h0
- count  output  IMEM_AW+1  words written since reset; saturating
- empty  output  1  FIFO empty
- err  output  1  sticky: illegal in_fmt accepted

## Operation
- Encode (combinational, on handshake), with `inst` as the output word:
  - R: `inst = {func7, rs2, rs1, func3, rd, opcode}`.
  - I: `inst = {imm[11:0], rs1, func3, rd, opcode}`.
  - S: `inst = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}`.
  - B: `inst = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}`.
  - U: `inst = {imm[31:12], rd, opcode}`.
  - J: `inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}`.
  - Fields not used by the format are ignored; imm bits outside the format's range are ignored. No range checking.
- Accept: when in_valid && in_ready, the encoded word is pushed into the FIFO.
- Illegal fmt (6, 7): the handshake completes, nothing is pushed, and err is set. err clears only on rst.
- Drain: when !empty && !imem_busy:
  - Drive imem_we=4'hF, imem_addr=wptr, imem_din=FIFO head.
  - Pop the head; wptr+1 mod 2^IMEM_AW; count+1, saturating at all-ones.
  - Otherwise imem_we=0 and imem_addr/imem_din hold their last values.
- wptr wraps from 2^IMEM_AW−1 to 0 silently.
- base_load:
  - Sets wptr=base_addr at the next edge.
  - Priority over increment. A write in the same cycle uses the old wptr; the next write uses base_addr.
  - Entries still in the FIFO are written at the new addresses.
- Simultaneous push and pop are allowed when not full; occupancy is unchanged.
- When full, in_ready=0 even if a pop occurs that cycle; there is no same-cycle pass-through.
- Reset mid-stream: FIFO contents are discarded, no further write is issued, and pending words are lost.

## Timing
- Reset values: wptr=0, count=0, err=0, empty=1, imem_we=0, imem_addr=0, imem_din=0. in_ready=0 while rst is high and 1 in the first cycle after.
- imem_we/imem_addr/imem_din are combinational from FIFO head, wptr and imem_busy; there is no extra output register.
- Latency: a word accepted at edge k is written in cycle k+1, provided the FIFO was empty and imem_busy=0.
- Throughput: 1 word/cycle sustained with in_valid=1 and imem_busy=0. The FIFO never fills in that case.
- Under imem_busy=1, in_ready falls after DEPTH accepts. It recovers in the cycle after the first pop edge.
- empty updates at the edge after the last pop. count is registered.

## Test plan
- R-type encode: opcode=7'h33, rd=5, func3=0, rs1=6, rs2=7, func7=7'h20 (sub x5,x6,x7). Required: one write, imem_din=32'h407302B3, imem_addr=0, imem_we=4'hF, one cycle after accept.
- I/S/B/U/J encode:
  - addi x1,x0,−1 → 32'hFFF00093.
  - sw x2,8(x1) → 32'h0020A423.
  - beq x0,x0,−4 → 32'hFE000EE3.
  - lui x3,0x12345 with imm=32'h12345000 → 32'h123451B7.
  - jal x1,2048 → 32'h001000EF.
  - Issue all five back-to-back. Required: addresses 0..4, count=5.
- Backpressure: hold imem_busy=1 and push DEPTH+2 bundles. Required: in_ready=0 after 4 accepts, no writes, empty=0. Release imem_busy. Required: 4 writes on consecutive cycles, then the remaining 2, in order.
- Wrap + base_load: base_load with base_addr=2^IMEM_AW−2, then push 3 words. Required: addresses 3FFE, 3FFF, 0000. A base_load=5 coincident with the 2nd write leaves it at 3FFF; the 3rd word goes to 5.
- Illegal fmt: push in_fmt=6, then a valid R-type. Required: err=1, only one write, at address 0.
- Reset mid-stream: imem_busy=1 with 3 words queued, then pulse rst. Required: empty=1, count=0, wptr=0, err=0, and no write after releasing imem_busy.
